// File: rtl/dac_readback_if.sv
// rtl/dac_readback_if.sv - AD5313R readback request/response port and shared DAC serial pins
interface dac_readback_if;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [3:0]  rd_addr;
    logic        rd_rsp_valid;
    logic        rd_rsp_ready;
    logic [15:0] rd_data;
    logic        rd_err;
    logic        bus_req;
    logic        bus_grant;
    logic        sclk;
    logic        sync_n;
    logic        sdin;
    logic        sdo;

    modport slave (
        input  rd_req_valid, rd_addr, rd_rsp_ready, bus_grant, sdo,
        output rd_req_ready, rd_rsp_valid, rd_data, rd_err, bus_req, sclk, sync_n, sdin
    );

    modport master (
        output rd_req_valid, rd_addr, rd_rsp_ready, bus_grant, sdo,
        input  rd_req_ready, rd_rsp_valid, rd_data, rd_err, bus_req, sclk, sync_n, sdin
    );
endinterface

// File: rtl/dac_readback.sv
// rtl/dac_readback.sv - AD5313R register readback: command frame, gap, NOP frame capturing SDO
module dac_readback #(
    parameter int CLK_DIV         = 4,
    parameter int SYNC_GAP        = 4,
    parameter int WATCH_DOG_WIDTH = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    dac_readback_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_F1,
        S_GAP,
        S_F2,
        S_RESP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(SYNC_GAP - 1);
    localparam logic [WATCH_DOG_WIDTH-1:0] WD_LAST = {{(WATCH_DOG_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WATCH_DOG_WIDTH-1:0] WD_ONE  = {{(WATCH_DOG_WIDTH-1){1'b0}}, 1'b1};

    state_t                     r_state;
    state_t                     w_next;
    logic [15:0]                r_div;
    logic                       r_half;
    logic [4:0]                 r_bit;
    logic [15:0]                r_gap;
    logic [WATCH_DOG_WIDTH-1:0] r_wdog;
    logic [3:0]                 r_addr;
    logic [23:0]                r_tx;
    logic [23:0]                r_rx;
    logic [15:0]                r_data;
    logic                       r_err;

    logic w_in_frame;
    logic w_half_end;
    logic w_bit_end;
    logic w_frame_end;
    logic w_addr_ok;
    logic w_timeout;
    logic w_gap_end;
    logic w_accept;

    // r_half=0 is the sclk-high half of a bit, r_half=1 the low half
    assign w_in_frame  = (r_state == S_F1) || (r_state == S_F2);
    assign w_half_end  = (r_div == DIV_LAST);
    assign w_bit_end   = w_half_end && r_half;
    assign w_frame_end = w_bit_end && (r_bit == 5'd23);
    assign w_addr_ok   = (bus.rd_addr == 4'b0001) || (bus.rd_addr == 4'b0010);
    assign w_timeout   = (r_wdog == WD_LAST);
    assign w_gap_end   = (r_gap == GAP_LAST);
    assign w_accept    = (r_state == S_IDLE) && bus.rd_req_valid;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.rd_req_valid) w_next = w_addr_ok ? S_ARB : S_RESP;
            S_ARB: begin
                if (bus.bus_grant)  w_next = S_F1;
                else if (w_timeout) w_next = S_RESP;
            end
            S_F1:   if (w_frame_end) w_next = S_GAP;
            S_GAP:  if (w_gap_end) w_next = S_F2;
            S_F2:   if (w_frame_end) w_next = S_RESP;
            S_RESP: if (bus.rd_rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_div  <= '0;
            r_half <= 1'b0;
            r_bit  <= '0;
            r_gap  <= '0;
            r_wdog <= '0;
            r_addr <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_in_frame && !w_frame_end) begin
                if (w_half_end) begin
                    r_div  <= '0;
                    r_half <= ~r_half;
                    if (r_half) r_bit <= r_bit + 5'd1;
                end else begin
                    r_div <= r_div + 16'd1;
                end
            end else begin
                r_div  <= '0;
                r_half <= 1'b0;
                r_bit  <= '0;
            end

            r_gap  <= (r_state == S_GAP) ? r_gap + 16'd1 : '0;
            r_wdog <= (r_state == S_ARB) ? r_wdog + WD_ONE : '0;

            if (w_accept) r_addr <= bus.rd_addr;

            // sdin is the MSB; the word advances on each sclk rising edge
            if ((r_state == S_ARB) && bus.bus_grant) r_tx <= {4'b1001, r_addr, 16'h0000};
            else if (r_state == S_GAP)               r_tx <= '0;
            else if (w_in_frame && w_bit_end)        r_tx <= {r_tx[22:0], 1'b0};

            if ((r_state == S_F2) && w_half_end && !r_half) r_rx <= {r_rx[22:0], bus.sdo};

            if (w_accept && !w_addr_ok) begin
                r_data <= '0;
                r_err  <= 1'b1;
            end else if ((r_state == S_ARB) && !bus.bus_grant && w_timeout) begin
                r_data <= '0;
                r_err  <= 1'b1;
            end else if ((r_state == S_F2) && w_frame_end) begin
                r_data <= r_rx[15:0];
                r_err  <= 1'b0;
            end
        end
    end

    assign bus.rd_req_ready = (r_state == S_IDLE);
    assign bus.rd_rsp_valid = (r_state == S_RESP);
    assign bus.rd_data      = r_data;
    assign bus.rd_err       = r_err;
    assign bus.bus_req      = (r_state == S_ARB) || (r_state == S_GAP) || w_in_frame;
    assign bus.sclk         = w_in_frame ? ~r_half : 1'b1;
    assign bus.sync_n       = ~w_in_frame;
    assign bus.sdin         = w_in_frame & r_tx[23];
endmodule

// File: doc/dac_readback.md
Name: dac_readback

Overview:
- Reader side of the AD5313R serial interface. The existing DAC control path only writes DAC registers; this block reads a DAC channel register back over SDO.
- It issues an AD5313R readback command frame, then a NOP frame, captures SDO during the NOP frame, and returns the 16-bit register word on a valid/ready response port.
- It shares the DAC serial pins with the DAC writer. Access is through a request/grant pair to the board-level pin arbiter.

Parameters:
- CLK_DIV, 4, sys_clk cycles per SCLK half-period (≥2).
- SYNC_GAP, 4, sys_clk cycles sync_n is held high between the two frames (≥2).
- WATCH_DOG_WIDTH, 12, width of the grant-wait timeout counter; timeout = 2^WATCH_DOG_WIDTH-1 cycles.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  asynchronous reset, active-high
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  block idle, request accepted when valid&ready
- rd_addr  in  4  AD5313R address nibble: 4'b0001 = DAC A, 4'b0010 = DAC B
- rd_rsp_valid  out  1  response valid
- rd_rsp_ready  in  1  response consumed
- rd_data  out  16  captured register word
- rd_err  out  1  response is an error (bad address or grant timeout)
- bus_req  out  1  request for the DAC serial pins
- bus_grant  in  1  pins granted to this block
- sclk  out  1  serial clock, idle high
- sync_n  out  1  frame sync, active low
- sdin  out  1  serial data to DAC, MSB first
- sdo  in  1  serial data from DAC

Behaviour:
- Reset (async, any state): state IDLE. Outputs: rd_req_ready=1, rd_rsp_valid=0, rd_data=0, rd_err=0, bus_req=0, sclk=1, sync_n=1, sdin=0. All counters cleared. A frame in progress is abandoned immediately.
- IDLE: rd_req_ready=1. On rd_req_valid, latch rd_addr and set rd_req_ready=0 on the next cycle.
  - Address 0001 or 0010: go to ARB.
  - Any other address: go to RESP with rd_err=1 and rd_data=0. No SPI activity and no bus_req.
- ARB: bus_req=1 and the watchdog counts.
  - bus_grant=1: go to F1.
  - Watchdog reaches its terminal count first: drop bus_req and go to RESP with rd_err=1, rd_data=0.
  - bus_grant is sampled only in ARB. The arbiter does not revoke it while bus_req=1.
- Frame timing (F1 and F2, 24 bits each, index k=0..23, MSB first):
  - sync_n=0 from the first cycle of the state.
  - Bit k is driven on sdin from cycle 2k·CLK_DIV.
  - sclk is high for cycles [2k·CLK_DIV, (2k+1)·CLK_DIV) and low for [(2k+1)·CLK_DIV, (2k+2)·CLK_DIV). The DAC samples sdin on the falling edge.
  - At cycle 48·CLK_DIV: sclk=1, sync_n=1, sdin=0, and the frame ends. A frame therefore holds sync_n low for exactly 48·CLK_DIV cycles.
- F1 word: {4'b1001, addr[3:0], 16'h0000} (readback command). Then go to GAP.
- GAP: sync_n=1 and sclk=1 for SYNC_GAP cycles, then go to F2.
- F2 word: 24'h000000 (NOP).
  - sdo is sampled on the sys_clk edge where sclk goes low, i.e. cycle (2k+1)·CLK_DIV, and shifted into a 24-bit register MSB first.
  - At frame end: rd_data = shift[15:0], rd_err=0. Drop bus_req the same cycle and go to RESP.
- RESP: rd_rsp_valid=1. rd_data and rd_err are held stable until rd_rsp_ready=1. On the handshake cycle, rd_rsp_valid drops, rd_req_ready rises, and the state returns to IDLE.
  - rd_data and rd_err keep their last value afterwards; they are meaningful only while rd_rsp_valid=1.
- Simultaneous events:
  - rd_req_valid outside IDLE is ignored; it is not queued.
  - rd_rsp_ready without rd_rsp_valid is ignored.
  - rd_rsp_ready held high: RESP lasts exactly 1 cycle.
- Latency from request accept to rd_rsp_valid, with immediate grant: 1 (ARB) + 48·CLK_DIV + SYNC_GAP + 48·CLK_DIV + 1 cycles. With default parameters this is 390 cycles.

Test Plan:
- rd_addr=4'b0001, grant after 3 cycles, DAC model drives 24'h00FFC0 on SDO in F2 (CLK_DIV=4).
  → F1 sdin word 0x910000 captured at sclk falling edges. Each frame has sync_n low for 192 cycles; gap is 4 cycles. rd_rsp_valid with rd_data=16'hFFC0, rd_err=0. bus_req low after F2.
- rd_addr=4'b0010, SDO word 24'h005540 → F1 word 0x920000, rd_data=16'h5540.
- rd_addr=4'b0100 → rd_rsp_valid within 2 cycles with rd_err=1, rd_data=0. sync_n and bus_req never asserted.
- bus_grant held 0, WATCH_DOG_WIDTH=4 → bus_req high 15 cycles then low; response rd_err=1; sclk and sync_n stay idle.
- rd_rsp_ready held 0 for 20 cycles while a second rd_req_valid pulses → rd_data stable, rd_req_ready=0, second request not executed. After ready, IDLE; the next request works.
- sys_rst asserted at bit 10 of F1 → sync_n=1, sclk=1, bus_req=0 asynchronously. After release, rd_req_ready=1, and a new read of addr 0001 completes correctly.
